// File: rtl/digaclock_set_ctrl.sv
// digaclock_set_ctrl: button sequencer for the time/alarm load interface of the 10 Hz alarm clock.
// Latency: a button edge acts at the next clk edge; load/stop strobes stay high for LOAD_HOLD cycles.
// Backpressure: none; button events during a load hold are discarded, never queued.
// Optional feature: define DIGACLOCK_AUTOREPEAT_EN for btn_up auto-repeat in the edit states.
module digaclock_set_ctrl #(
  parameter int LOAD_HOLD  = 12,
  parameter int REPEAT_DLY = 5,
  parameter int REPEAT_PER = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_cancel,
  input  logic       Alarm,
  input  logic [1:0] H_cur1,
  input  logic [3:0] H_cur0,
  input  logic [3:0] M_cur1,
  input  logic [3:0] M_cur0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [2:0] edit_field
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ET_H = 3'd1;
  localparam logic [2:0] S_ET_M = 3'd2;
  localparam logic [2:0] S_LD_T = 3'd3;
  localparam logic [2:0] S_EA_H = 3'd4;
  localparam logic [2:0] S_EA_M = 3'd5;
  localparam logic [2:0] S_LD_A = 3'd6;

  localparam int            CW        = $clog2(LOAD_HOLD + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(LOAD_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] stop_cnt_q, stop_cnt_d;
  logic [1:0]    h1_q, h1_d, ah1_q, ah1_d;
  logic [3:0]    h0_q, h0_d, ah0_q, ah0_d;
  logic [3:0]    m1_q, m1_d, am1_q, am1_d;
  logic [3:0]    m0_q, m0_d, am0_q, am0_d;
  logic          ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
  logic          stop_al_q, stop_al_d, al_on_q, al_on_d;
  logic          mode_prev_q, up_prev_q, cancel_prev_q;
  logic          ev_cancel, ev_mode, ev_up, rep_fire, inc_req, is_edit;

  // Hours wrap 23 -> 00 in BCD; out-of-range digits collapse to a legal value.
  function automatic logic [5:0] inc_hours(input logic [1:0] h1, input logic [3:0] h0);
    if (h1 >= 2'd2 && h0 >= 4'd3) return 6'd0;
    else if (h0 >= 4'd9)          return {h1 + 2'd1, 4'd0};
    else                          return {h1, h0 + 4'd1};
  endfunction

  // Minutes wrap 59 -> 00 without carrying into hours.
  function automatic logic [7:0] inc_minutes(input logic [3:0] m1, input logic [3:0] m0);
    if (m0 >= 4'd9) return (m1 >= 4'd5) ? 8'd0 : {m1 + 4'd1, 4'd0};
    else            return {m1, m0 + 4'd1};
  endfunction

  // Rising-edge events with a single winner per cycle: cancel, then mode, then up.
  always_comb begin
    ev_cancel = btn_cancel & ~cancel_prev_q;
    ev_mode   = btn_mode & ~mode_prev_q & ~ev_cancel;
    ev_up     = btn_up & ~up_prev_q & ~ev_cancel & ~ev_mode;
    is_edit   = (state_q == S_ET_H) || (state_q == S_ET_M) ||
                (state_q == S_EA_H) || (state_q == S_EA_M);
    inc_req   = ev_up | (rep_fire & ~ev_cancel & ~ev_mode);
  end

`ifdef DIGACLOCK_AUTOREPEAT_EN
  logic [7:0] rep_cnt_q, rep_cnt_d;

  // Count held cycles after the edge; fire after REPEAT_DLY, then every REPEAT_PER.
  always_comb begin
    rep_cnt_d = 8'd0;
    rep_fire  = 1'b0;
    if (is_edit && btn_up && up_prev_q) begin
      if (rep_cnt_q == 8'(REPEAT_DLY)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = 8'(REPEAT_DLY - REPEAT_PER + 1);
      end else begin
        rep_cnt_d = rep_cnt_q + 8'd1;
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk) begin
    if (reset) rep_cnt_q <= 8'd0;
    else       rep_cnt_q <= rep_cnt_d;
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DLY + REPEAT_PER;
  assign rep_fire = 1'b0;
`endif

  // Edit sequencer: state transitions, entry copies, field increments and strobe holds.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stop_cnt_d = stop_cnt_q;
    h1_d = h1_q;   h0_d = h0_q;   m1_d = m1_q;   m0_d = m0_q;
    ah1_d = ah1_q; ah0_d = ah0_q; am1_d = am1_q; am0_d = am0_q;
    ld_time_d  = ld_time_q;
    ld_alarm_d = ld_alarm_q;
    stop_al_d  = stop_al_q;
    al_on_d    = al_on_q;

    if (stop_al_q) begin
      if (stop_cnt_q == '0) stop_al_d  = 1'b0;
      else                  stop_cnt_d = stop_cnt_q - CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (ev_cancel) begin
          if (Alarm) begin
            stop_al_d  = 1'b1;
            stop_cnt_d = HOLD_INIT;
          end
        end else if (ev_mode) begin
          state_d = S_ET_H;
          h1_d = H_cur1; h0_d = H_cur0; m1_d = M_cur1; m0_d = M_cur0;
        end else if (ev_up) begin
          al_on_d = ~al_on_q;
        end
      end
      S_ET_H, S_EA_H: begin
        if (ev_cancel)    state_d = S_IDLE;
        else if (ev_mode) state_d = (state_q == S_ET_H) ? S_ET_M : S_EA_M;
        else if (inc_req) {h1_d, h0_d} = inc_hours(h1_q, h0_q);
      end
      S_ET_M, S_EA_M: begin
        if (ev_cancel) begin
          state_d = S_IDLE;
        end else if (ev_mode) begin
          hold_cnt_d = HOLD_INIT;
          if (state_q == S_ET_M) begin
            state_d   = S_LD_T;
            ld_time_d = 1'b1;
          end else begin
            state_d    = S_LD_A;
            ld_alarm_d = 1'b1;
            ah1_d = h1_q; ah0_d = h0_q; am1_d = m1_q; am0_d = m0_q;
          end
        end else if (inc_req) begin
          {m1_d, m0_d} = inc_minutes(m1_q, m0_q);
        end
      end
      S_LD_T: begin
        if (hold_cnt_q == '0) begin
          ld_time_d = 1'b0;
          state_d   = S_EA_H;
          h1_d = ah1_q; h0_d = ah0_q; m1_d = am1_q; m0_d = am0_q;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_ONE;
        end
      end
      S_LD_A: begin
        if (hold_cnt_q == '0) begin
          ld_alarm_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, edit/shadow registers, strobes and button history with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  hold_cnt_q <= '0;  stop_cnt_q <= '0;
      h1_q <= '0;  h0_q <= '0;  m1_q <= '0;  m0_q <= '0;
      ah1_q <= '0; ah0_q <= '0; am1_q <= '0; am0_q <= '0;
      ld_time_q <= 1'b0; ld_alarm_q <= 1'b0; stop_al_q <= 1'b0; al_on_q <= 1'b0;
      mode_prev_q <= 1'b0; up_prev_q <= 1'b0; cancel_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;  hold_cnt_q <= hold_cnt_d;  stop_cnt_q <= stop_cnt_d;
      h1_q <= h1_d;   h0_q <= h0_d;   m1_q <= m1_d;   m0_q <= m0_d;
      ah1_q <= ah1_d; ah0_q <= ah0_d; am1_q <= am1_d; am0_q <= am0_d;
      ld_time_q <= ld_time_d; ld_alarm_q <= ld_alarm_d;
      stop_al_q <= stop_al_d; al_on_q <= al_on_d;
      mode_prev_q <= btn_mode; up_prev_q <= btn_up; cancel_prev_q <= btn_cancel;
    end
  end

  assign H_in1      = h1_q;
  assign H_in0      = h0_q;
  assign M_in1      = m1_q;
  assign M_in0      = m0_q;
  assign LD_time    = ld_time_q;
  assign LD_alarm   = ld_alarm_q;
  assign STOP_al    = stop_al_q;
  assign AL_ON      = al_on_q;
  assign edit_field = state_q;

endmodule
